// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The multiply/divide timer state, its counter width, and the per-stage
// hold/clear control pair all live here so every file agrees on them.
package hazard_pkg;

  // Multiply/divide unit tracking state.
  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Width of the multiply/divide busy down-counter (latency up to 255).
  localparam int MD_CNT_W = 8;

  // Synchronous control pair for one pipeline-stage register.
  typedef struct packed {
    logic hold;
    logic clear;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_NONE  = '{hold: 1'b0, clear: 1'b0};
  localparam stage_ctl_t CTL_HOLD  = '{hold: 1'b1, clear: 1'b0};
  localparam stage_ctl_t CTL_CLEAR = '{hold: 1'b0, clear: 1'b1};

endpackage

// File: rtl/md_timer.sv
// Multiply/divide busy tracker.
// Two-state FSM (RUN / MD_BUSY) with an 8-bit down-counter. A start is
// accepted only when the pipeline is not frozen by a memory wait, because
// the issuing instruction stays in EX and re-presents the start afterwards.
// Once running, the counter decrements every cycle regardless of freezes:
// the arithmetic unit runs independently of the pipeline registers.
// A start while already busy (after a flush) reloads the counter.
module md_timer
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic freeze_in,
  output logic busy
);

  // Counter value loaded on issue; the unit is busy for MD_LAT-1 cycles
  // after the issue cycle.
  localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LAT - 1);
  localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

  md_state_t             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  accept;

  assign accept = start & ~freeze_in;

  // State and counter registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (accept) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == CNT_ONE) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Busy is a direct decode of the state register.
  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
// Drives the synchronous hold/clear inputs of IF/ID, ID/EX, EX/MEM and
// MEM/WB plus the PC hold. Resolution order, highest first: data-memory
// wait (full freeze), EX redirect (squash IF/ID and ID/EX), load-use
// bubble, multiply/divide-busy bubble.
// Outputs are combinational because the stage registers sample them on
// the same clock edge they are computed for.
// Optional build macro HAZ_PERF_CNT_EN adds stall_cycles and flush_count
// performance counters.
//
// Handshake: there is no valid/ready exchange here; dmem_req/dmem_ready is
// a level pair where a pending request without ready means "not done this
// cycle", and the pipeline freezes until ready is seen with req.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int RW     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic          id_md_use,
  input  logic [RW-1:0] ex_rt,
  input  logic          ex_memread,
  input  logic          ex_redirect,
  input  logic          ex_md_start,
  input  logic          dmem_req,
  input  logic          dmem_ready,
  output logic          pc_hold,
  output logic          ifid_hold,
  output logic          ifid_clear,
  output logic          idex_hold,
  output logic          idex_clear,
  output logic          exmem_hold,
  output logic          exmem_clear,
  output logic          memwb_hold,
  output logic          memwb_clear,
  output logic          md_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   flush_count
`endif
);

  logic       mem_wait;
  logic       load_use;
  logic       md_stall;
  logic       redirect_win;
  logic       pc_hold_c;
  stage_ctl_t ifid_c, idex_c, exmem_c, memwb_c;

  assign mem_wait = dmem_req & ~dmem_ready;

  // A load into r0 never creates a dependency.
  assign load_use = ex_memread & (ex_rt != '0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  assign md_stall = md_busy & id_md_use;

  // Redirect only takes effect when the pipeline is not frozen.
  assign redirect_win = ex_redirect & ~mem_wait;

  md_timer #(
    .MD_LAT (MD_LAT)
  ) u_md_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (ex_md_start),
    .freeze_in (mem_wait),
    .busy      (md_busy)
  );

  // Priority resolution of stage controls; reset forces all clears.
  always_comb begin
    pc_hold_c = 1'b0;
    ifid_c    = CTL_NONE;
    idex_c    = CTL_NONE;
    exmem_c   = CTL_NONE;
    memwb_c   = CTL_NONE;
    if (!rst_n) begin
      ifid_c  = CTL_CLEAR;
      idex_c  = CTL_CLEAR;
      exmem_c = CTL_CLEAR;
      memwb_c = CTL_CLEAR;
    end else if (mem_wait) begin
      pc_hold_c = 1'b1;
      ifid_c    = CTL_HOLD;
      idex_c    = CTL_HOLD;
      exmem_c   = CTL_HOLD;
      memwb_c   = CTL_HOLD;
    end else if (ex_redirect) begin
      // Squash the two younger instructions; any ID stall is moot.
      ifid_c = CTL_CLEAR;
      idex_c = CTL_CLEAR;
    end else if (load_use | md_stall) begin
      // Keep PC and IF/ID, insert one bubble into ID/EX.
      pc_hold_c = 1'b1;
      ifid_c    = CTL_HOLD;
      idex_c    = CTL_CLEAR;
    end
  end

  assign pc_hold     = pc_hold_c;
  assign ifid_hold   = ifid_c.hold;
  assign ifid_clear  = ifid_c.clear;
  assign idex_hold   = idex_c.hold;
  assign idex_clear  = idex_c.clear;
  assign exmem_hold  = exmem_c.hold;
  assign exmem_clear = exmem_c.clear;
  assign memwb_hold  = memwb_c.hold;
  assign memwb_clear = memwb_c.clear;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  // Performance counters: cycles with PC held, and cycles squashed by redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (pc_hold_c) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (redirect_win) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  // Without counters the redirect qualifier has no consumer.
  logic unused_redirect_win;
  assign unused_redirect_win = redirect_win;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by randomized traffic,
// all checked against a cycle-level reference model that tracks the
// multiply/divide unit as "remaining busy cycles" and derives the stage
// controls from the hazard priority rules.
module tb_hazard_ctrl;
  localparam int MD_LAT = 4;
  localparam int RW     = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_rs, id_rt, ex_rt;
  logic          id_uses_rt, id_md_use, ex_memread, ex_redirect;
  logic          ex_md_start, dmem_req, dmem_ready;
  logic          pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear;
  logic          exmem_hold, exmem_clear, memwb_hold, memwb_clear, md_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]   stall_cycles, flush_count;
`endif

  hazard_ctrl #(.MD_LAT(MD_LAT), .RW(RW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_md_use   (id_md_use),
    .ex_rt       (ex_rt),
    .ex_memread  (ex_memread),
    .ex_redirect (ex_redirect),
    .ex_md_start (ex_md_start),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .pc_hold     (pc_hold),
    .ifid_hold   (ifid_hold),
    .ifid_clear  (ifid_clear),
    .idex_hold   (idex_hold),
    .idex_clear  (idex_clear),
    .exmem_hold  (exmem_hold),
    .exmem_clear (exmem_clear),
    .memwb_hold  (memwb_hold),
`ifdef HAZ_PERF_CNT_EN
    .stall_cycles(stall_cycles),
    .flush_count (flush_count),
`endif
    .memwb_clear (memwb_clear),
    .md_busy     (md_busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [9:0]  exp_q[$];
  int          md_rem;        // cycles the MD unit remains busy
  int unsigned m_stall;
  int unsigned m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Expected control vector, ordered
  // {pc_hold, ifid_h, ifid_c, idex_h, idex_c, exmem_h, exmem_c, memwb_h, memwb_c, md_busy}
  function automatic logic [9:0] model_out();
    logic mw, lu, st, busy;
    busy = (md_rem > 0);
    mw   = dmem_req && !dmem_ready;
    lu   = ex_memread && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    st   = lu || (busy && id_md_use);
    if (!rst_n)           return 10'b0010101010;
    else if (mw)          return {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, busy};
    else if (ex_redirect) return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, busy};
    else if (st)          return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, busy};
    else                  return {9'b0, busy};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 1'b0; id_md_use = 1'b0; ex_memread = 1'b0;
    ex_redirect = 1'b0; ex_md_start = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Inputs are already applied (just after a rising edge). Check at the
  // falling edge, then advance the model across the next rising edge.
  task automatic run_cycle(input string tag);
    logic [9:0] e, obs;
    logic       mw;
    e = model_out();
    exp_q.push_back(e);
    @(negedge clk);
    obs = {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
           exmem_hold, exmem_clear, memwb_hold, memwb_clear, md_busy};
    check(tag, {22'd0, obs}, {22'd0, exp_q.pop_front()});
`ifdef HAZ_PERF_CNT_EN
    check({tag, "_stall_cnt"}, stall_cycles, m_stall);
    check({tag, "_flush_cnt"}, flush_count, m_flush);
`endif
    @(posedge clk);
    if (rst_n) begin
      mw = dmem_req && !dmem_ready;
      if (ex_md_start && !mw) md_rem = MD_LAT - 1;
      else if (md_rem > 0)    md_rem = md_rem - 1;
      if (e[9])                  m_stall++;
      if (ex_redirect && !mw)    m_flush++;
    end
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst_n   = 1'b0;
    md_rem  = 0;
    m_stall = 0;
    m_flush = 0;
    for (int i = 0; i < n; i++) run_cycle("reset");
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    for (int i = 0; i < n; i++) run_cycle("idle");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    md_rem = 0; m_stall = 0; m_flush = 0;
    rst_n = 1'b0;
    #1;
    apply_reset(3);
    idle_cycles(2);

    // Load-use on rs: one bubble, then the load leaves EX.
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    run_cycle("load_use_rs");
    idle_cycles(1);
    // Load-use on rt only when the ID instruction reads rt.
    ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    run_cycle("load_use_rt");
    id_uses_rt = 1'b0;
    run_cycle("load_rt_unused");
    // Load into r0 never stalls.
    set_idle(); ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    run_cycle("load_r0");
    // Redirect beats load-use.
    set_idle(); ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; ex_redirect = 1'b1;
    run_cycle("redirect_lu");
    idle_cycles(1);

    // Mult/div issue then dependent md instruction in ID.
    ex_md_start = 1'b1;
    run_cycle("md_issue");
    ex_md_start = 1'b0; id_md_use = 1'b1;
    for (int i = 0; i < MD_LAT; i++) run_cycle("md_stall");
    idle_cycles(1);

    // Memory wait during MD_BUSY; start during wait is refused.
    ex_md_start = 1'b1;
    run_cycle("md_issue2");
    set_idle(); dmem_req = 1'b1; ex_md_start = 1'b1; ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
    for (int i = 0; i < 5; i++) run_cycle("mem_wait");
    dmem_ready = 1'b1;
    run_cycle("wait_release");
    set_idle(); id_md_use = 1'b1;
    for (int i = 0; i < MD_LAT; i++) run_cycle("md_after_wait");
    // Restart while busy after a flush.
    set_idle(); ex_md_start = 1'b1;
    run_cycle("md_issue3");
    run_cycle("md_restart");
    set_idle(); id_md_use = 1'b1;
    for (int i = 0; i < MD_LAT; i++) run_cycle("md_post_restart");
    // Reset mid-operation abandons the operation.
    set_idle(); ex_md_start = 1'b1;
    run_cycle("md_issue4");
    set_idle();
    apply_reset(2);
    id_md_use = 1'b1;
    run_cycle("md_after_reset");

    // Perf scenario: 1 load-use + 5 wait cycles + 1 redirect.
    apply_reset(1);
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    run_cycle("perf_lu");
    set_idle(); dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) run_cycle("perf_wait");
    dmem_ready = 1'b1;
    run_cycle("perf_release");
    set_idle(); ex_redirect = 1'b1;
    run_cycle("perf_redirect");
    idle_cycles(1);
`ifdef HAZ_PERF_CNT_EN
    @(negedge clk);
    check("perf_stall_total", stall_cycles, 32'd6);
    check("perf_flush_total", flush_count, 32'd1);
    @(posedge clk); #1;
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      id_rs       = RW'($urandom_range(0, 3));
      id_rt       = RW'($urandom_range(0, 3));
      ex_rt       = RW'($urandom_range(0, 3));
      id_uses_rt  = ($urandom_range(0, 1) == 1);
      id_md_use   = ($urandom_range(0, 9) < 3);
      ex_memread  = ($urandom_range(0, 9) < 3);
      ex_redirect = ($urandom_range(0, 19) < 3);
      ex_md_start = ($urandom_range(0, 9) == 0);
      dmem_req    = ($urandom_range(0, 9) < 3);
      dmem_ready  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 299) == 0) apply_reset($urandom_range(1, 2));
      else run_cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
